pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_sat_counter.sv | 33 +++
 rtl/pipe_stage_reg.sv | 144 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage register and its helpers.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    localparam int unsigned PIPE_CNT_W = 16;

    // Number of beats held in a given storage state.
    function automatic logic [1:0] pipe_occupancy(input pipe_state_e st);
        logic [1:0] occ;
        case (st)
            EMPTY:   occ = 2'd0;
            ONE:     occ = 2'd1;
            FULL:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear, updated on the falling clock edge.
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Next count: clear wins, then increment unless already all-ones.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_clr) begin
            w_cnt_nxt = {CNT_W{1'b0}};
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Count register.
    always_ff @(negedge clk) begin
        r_cnt <= w_cnt_nxt;
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry (main + skid) pipeline stage register with valid/ready handshakes and flush.
// Optional performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH   = 107,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
    parameter int               CNT_W   = PIPE_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
`endif
);

    pipe_state_e      r_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [1:0]       r_occ;

    pipe_state_e      w_state_nxt;
    logic [WIDTH-1:0] w_main_nxt;
    logic [WIDTH-1:0] w_skid_nxt;
    logic             w_in_fire;
    logic             w_out_fire;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    // Next-state and storage update; flush squashes everything including a same-cycle accept.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = EMPTY;
            w_main_nxt  = RST_VAL;
            w_skid_nxt  = RST_VAL;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt = ONE;
                        w_main_nxt  = in_data;
                    end else begin
                        w_state_nxt = EMPTY;
                    end
                end
                ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_state_nxt = ONE;
                        w_main_nxt  = in_data;
                    end else if (w_in_fire) begin
                        w_state_nxt = FULL;
                        w_skid_nxt  = in_data;
                    end else if (w_out_fire) begin
                        w_state_nxt = EMPTY;
                    end else begin
                        w_state_nxt = ONE;
                    end
                end
                FULL: begin
                    // The skid entry is the older of the two incoming beats' successor; promote it.
                    if (w_out_fire) begin
                        w_state_nxt = ONE;
                        w_main_nxt  = r_skid;
                    end else begin
                        w_state_nxt = FULL;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                    w_main_nxt  = RST_VAL;
                    w_skid_nxt  = RST_VAL;
                end
            endcase
        end
    end

    // State, storage and decoded status flags; status is registered so in_ready has no input path.
    always_ff @(negedge clk) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_main      <= RST_VAL;
            r_skid      <= RST_VAL;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_occ       <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_main      <= w_main_nxt;
            r_skid      <= w_skid_nxt;
            r_in_ready  <= (w_state_nxt != FULL);
            r_out_valid <= (w_state_nxt != EMPTY);
            r_occ       <= pipe_occupancy(w_state_nxt);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;
    assign occupancy = r_occ;

`ifdef PIPE_STAGE_PERF_EN
    logic w_stall_inc;
    logic w_bubble_inc;

    assign w_stall_inc  = r_out_valid & ~out_ready;
    assign w_bubble_inc = out_ready & ~r_out_valid;

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .i_clr (rst),
        .i_inc (w_stall_inc),
        .o_cnt (stall_cnt)
    );

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .i_clr (rst),
        .i_inc (w_bubble_inc),
        .o_cnt (bubble_cnt)
    );
`else
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: queue model of held beats checked every cycle.
module tb_pipe_stage_reg;

    localparam int W = 107;
    localparam logic [W-1:0] RV = {27'h0, 80'hDEAD_BEEF_0123_4567_89AB};
`ifdef PIPE_STAGE_PERF_EN
    localparam int CW = 4;
`else
    localparam int CW = 16;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] bubble_cnt;
`endif

    int errors = 0;
    int checks = 0;
    logic [W-1:0] q[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .WIDTH   (W),
        .RST_VAL (RV),
        .CNT_W   (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .occupancy  (occupancy)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    // Drive one cycle of inputs, update the reference queue at the falling edge, then settle.
    task automatic drive(input logic r, input logic v, input logic [W-1:0] d,
                         input logic ordy, input logic fl);
        logic m_rdy;
        logic m_vld;
        rst = r; in_valid = v; in_data = d; out_ready = ordy; flush = fl;
        m_rdy = (q.size() < 2);
        m_vld = (q.size() != 0);
        @(negedge clk);
        if (r || fl) begin
            q.delete();
        end else begin
            if (m_vld && ordy) void'(q.pop_front());
            if (v && m_rdy) q.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", occupancy); end
        checks++; if (out_data !== RV) begin errors++; $display("FAIL reset_data got %0h want %0h", out_data, RV); end
`ifdef PIPE_STAGE_PERF_EN
        checks++; if (stall_cnt !== 4'd0 || bubble_cnt !== 4'd0) begin
            errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cnt, bubble_cnt); end
`endif
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 1'b1, W'(i), 1'b1, 1'b0);
            checks++; if (out_valid !== 1'b1 || out_data !== W'(i)) begin
                errors++; $display("FAIL stream_data%0d got v=%b %0h want v=1 %0h", i, out_valid, out_data, i); end
            checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin
                errors++; $display("FAIL stream_occ%0d got %0d rdy=%b want 1 rdy=1", i, occupancy, in_ready); end
        end
        drive(1'b0, 1'b0, {W{1'b0}}, 1'b1, 1'b0);
        checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL stream_drain got occ=%0d v=%b want 0 0", occupancy, out_valid); end
    endtask

    task automatic test_backpressure();
        drive(1'b0, 1'b1, 107'hA, 1'b0, 1'b0);
        checks++; if (occupancy !== 2'd1 || out_data !== 107'hA) begin
            errors++; $display("FAIL bp_one got occ=%0d %0h want 1 a", occupancy, out_data); end
        drive(1'b0, 1'b1, 107'hB, 1'b0, 1'b0);
        checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 107'hA) begin
            errors++; $display("FAIL bp_full got occ=%0d rdy=%b %0h want 2 0 a", occupancy, in_ready, out_data); end
        drive(1'b0, 1'b1, 107'hD, 1'b0, 1'b0);
        checks++; if (occupancy !== 2'd2 || out_data !== 107'hA) begin
            errors++; $display("FAIL bp_hold got occ=%0d %0h want 2 a", occupancy, out_data); end
        drive(1'b0, 1'b0, {W{1'b0}}, 1'b1, 1'b0);
        checks++; if (occupancy !== 2'd1 || out_data !== 107'hB || out_data !== q[0]) begin
            errors++; $display("FAIL bp_second got occ=%0d %0h want 1 b", occupancy, out_data); end
        drive(1'b0, 1'b0, {W{1'b0}}, 1'b1, 1'b0);
        checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_empty got occ=%0d v=%b rdy=%b want 0 0 1", occupancy, out_valid, in_ready); end
    endtask

    task automatic test_flush();
        drive(1'b0, 1'b1, 107'h21, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 107'h22, 1'b0, 1'b0);
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL flush_fill got %0d want 2", occupancy); end
        drive(1'b0, 1'b1, 107'hC, 1'b0, 1'b1);
        checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_state got occ=%0d v=%b rdy=%b want 0 0 1", occupancy, out_valid, in_ready); end
        checks++; if (out_data !== RV) begin errors++; $display("FAIL flush_data got %0h want %0h", out_data, RV); end
        drive(1'b0, 1'b0, {W{1'b0}}, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b0 || out_data === 107'hC) begin
            errors++; $display("FAIL flush_no_c got v=%b %0h want 0", out_valid, out_data); end
        drive(1'b0, 1'b1, 107'hE, 1'b1, 1'b1);
        checks++; if (occupancy !== 2'd0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_wins got occ=%0d rdy=%b want 0 1", occupancy, in_ready); end
    endtask

    task automatic test_rst_flush();
        drive(1'b0, 1'b1, 107'h31, 1'b0, 1'b0);
        checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL rf_one got %0d want 1", occupancy); end
        drive(1'b1, 1'b1, 107'h32, 1'b1, 1'b1);
        checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== RV) begin
            errors++; $display("FAIL rf_state got occ=%0d v=%b rdy=%b %0h want 0 0 1 %0h",
                               occupancy, out_valid, in_ready, out_data, RV); end
`ifdef PIPE_STAGE_PERF_EN
        checks++; if (stall_cnt !== 4'd0 || bubble_cnt !== 4'd0) begin
            errors++; $display("FAIL rf_cnt got %0d/%0d want 0/0", stall_cnt, bubble_cnt); end
`endif
    endtask

    task automatic test_random();
        logic [W-1:0] d;
        for (int n = 0; n < 300; n++) begin
            d = W'({$urandom, $urandom, $urandom, $urandom});
            drive(1'b0, 1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 19) == 0));
            checks++; if (occupancy !== 2'(q.size())) begin
                errors++; $display("FAIL rnd_occ@%0d got %0d want %0d", n, occupancy, q.size()); end
            checks++; if (in_ready !== (q.size() < 2) || out_valid !== (q.size() != 0)) begin
                errors++; $display("FAIL rnd_flags@%0d got rdy=%b v=%b want occ %0d", n, in_ready, out_valid, q.size()); end
            if (q.size() != 0) begin
                checks++; if (out_data !== q[0]) begin
                    errors++; $display("FAIL rnd_data@%0d got %0h want %0h", n, out_data, q[0]); end
            end
        end
    endtask

`ifdef PIPE_STAGE_PERF_EN
    task automatic test_perf();
        drive(1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 107'h41, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0, {W{1'b0}}, 1'b0, 1'b0);
            if (i == 4) begin
                checks++; if (stall_cnt !== 4'd5) begin errors++; $display("FAIL stall_5 got %0d want 5", stall_cnt); end
            end
        end
        checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL stall_sat got %0d want 15", stall_cnt); end
        drive(1'b0, 1'b0, {W{1'b0}}, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, {W{1'b0}}, 1'b1, 1'b0);
        checks++; if (bubble_cnt !== 4'd3) begin errors++; $display("FAIL bubble_3 got %0d want 3", bubble_cnt); end
        drive(1'b0, 1'b0, {W{1'b0}}, 1'b0, 1'b1);
        checks++; if (stall_cnt !== 4'd15 || bubble_cnt !== 4'd3) begin
            errors++; $display("FAIL cnt_flush got %0d/%0d want 15/3", stall_cnt, bubble_cnt); end
    endtask
`endif

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = {W{1'b0}}; out_ready = 1'b0; flush = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_rst_flush();
        test_random();
`ifdef PIPE_STAGE_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
